// File: rtl/sha3_pad_absorb.sv
// sha3_pad_absorb: packs message beats into Keccak rate blocks with FIPS-202 padding
module sha3_pad_absorb #(
  parameter int IN_W = 64,
  localparam int NB = IN_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               mode,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [$clog2(NB+1)-1:0]  in_bytes,
  output logic                     in_ready,
  output logic [1599:0]            blk_data,
  output logic                     blk_valid,
  output logic                     blk_first,
  output logic                     blk_last,
  input  logic                     blk_ready,
  output logic                     busy
);
  localparam logic [7:0] NB8 = 8'(NB);
  typedef enum logic [1:0] {ACCUM, EMIT, PADBLK} state_t;
  state_t state_q, state_d;
  logic [1599:0] buf_q, buf_d;
  logic [7:0] ptr_q, ptr_d, rate_q, rate_d, rate, n, pos, nxt, dom;
  logic pad_q, pad_d, first_q, first_d, last_q, last_d, busy_q, busy_d, shake_q, shake_d, shake;
  logic [IN_W-1:0] beat;
  function automatic logic [7:0] rate_of(input logic [2:0] m);
    return m == 3'b000 ? 8'd72 : m == 3'b001 ? 8'd104 : m == 3'b010 ? 8'd144 :
           m == 3'b100 ? 8'd168 : 8'd136;
  endfunction
  // Beat packing, padding and block handshake sequencing
  always_comb begin
    rate = busy_q ? rate_q : rate_of(mode);
    shake = busy_q ? shake_q : (mode == 3'b100 || mode == 3'b101);
    dom = shake ? 8'h1F : 8'h06;
    n = 8'(in_bytes) > NB8 ? NB8 : 8'(in_bytes);
    beat = '0;
    for (int i = 0; i < NB; i++)
      beat[8*i +: 8] = (!in_last || 8'(i) < n) ? in_data[IN_W-1-8*i -: 8] : 8'h00;
    pos = ptr_q + n;
    nxt = ptr_q + NB8;
    state_d = state_q;
    buf_d = buf_q;
    ptr_d = ptr_q;
    rate_d = rate_q;
    shake_d = shake_q;
    pad_d = pad_q;
    first_d = first_q;
    last_d = last_q;
    busy_d = busy_q;
    if (state_q == ACCUM && in_valid) begin
      busy_d = 1'b1;
      rate_d = rate;
      shake_d = shake;
      first_d = busy_q ? first_q : 1'b1;
      buf_d[{ptr_q, 3'b000} +: IN_W] = beat;
      ptr_d = nxt;
      if (in_last) begin
        state_d = EMIT;
        last_d = pos < rate;
        pad_d = !(pos < rate);
        if (pos < rate) begin
          buf_d[{pos, 3'b000} +: 8] = buf_d[{pos, 3'b000} +: 8] ^ dom;
          buf_d[{rate - 8'd1, 3'b000} +: 8] = buf_d[{rate - 8'd1, 3'b000} +: 8] ^ 8'h80;
        end
      end else if (nxt == rate) begin
        state_d = EMIT;
        last_d = 1'b0;
      end
    end else if (state_q == EMIT && blk_ready) begin
      buf_d = '0;
      ptr_d = '0;
      first_d = 1'b0;
      busy_d = last_q ? 1'b0 : busy_q;
      state_d = pad_q ? PADBLK : ACCUM;
      pad_d = 1'b0;
    end else if (state_q == PADBLK) begin
      buf_d = '0;
      buf_d[7:0] = dom;
      buf_d[{rate - 8'd1, 3'b000} +: 8] = 8'h80;
      last_d = 1'b1;
      state_d = EMIT;
    end
  end
  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      buf_q <= '0;
      ptr_q <= '0;
      rate_q <= 8'd136;
      shake_q <= 1'b0;
      pad_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      ptr_q <= ptr_d;
      rate_q <= rate_d;
      shake_q <= shake_d;
      pad_q <= pad_d;
      first_q <= first_d;
      last_q <= last_d;
      busy_q <= busy_d;
    end
  end
  assign in_ready = state_q == ACCUM;
  assign blk_valid = state_q == EMIT;
  assign blk_first = blk_valid & first_q;
  assign blk_last = blk_valid & last_q;
  assign blk_data = buf_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_sha3_pad_absorb.sv
// tb_sha3_pad_absorb: scoreboard bench for the SHA-3 padding/absorb front end
module tb_sha3_pad_absorb;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, in_ready, blk_valid, blk_first, blk_last, blk_ready, busy;
  logic [2:0] mode;
  logic [63:0] in_data;
  logic [3:0] in_bytes;
  logic [1599:0] blk_data;
  typedef struct {logic [1599:0] d; logic f; logic l;} blk_t;
  blk_t sb[$];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  sha3_pad_absorb #(.IN_W(64)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready), .blk_data(blk_data),
    .blk_valid(blk_valid), .blk_first(blk_first), .blk_last(blk_last),
    .blk_ready(blk_ready), .busy(busy));
  task automatic chk(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      for (int k = 0; k < 200; k++)
        if (act[8*k +: 8] !== exp[8*k +: 8]) begin
          $display("FAIL %s: byte %0d got %h want %h", name, k, act[8*k +: 8], exp[8*k +: 8]);
          break;
        end
    end
  endtask
  function automatic logic [1599:0] mk(input int len, input int start, input logic [7:0] seed,
                                       input int dpos, input logic [7:0] dval, input int rpos);
    logic [1599:0] r;
    r = '0;
    for (int k = 0; k < len; k++) r[8*k +: 8] = seed + 8'(start + k);
    if (dpos >= 0) r[8*dpos +: 8] = r[8*dpos +: 8] ^ dval;
    if (rpos >= 0) r[8*rpos +: 8] = r[8*rpos +: 8] ^ 8'h80;
    return r;
  endfunction
  task automatic push(input logic [1599:0] d, input logic f, input logic l);
    blk_t b;
    b.d = d;
    b.f = f;
    b.l = l;
    sb.push_back(b);
  endtask
  task automatic send(input logic [2:0] m, input int len, input logic [7:0] seed, input bit tog);
    int nb;
    int cnt;
    nb = (len == 0) ? 1 : (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      cnt = 0;
      mode = (tog && b > 0) ? 3'b000 : m;
      for (int i = 0; i < 8; i++)
        in_data[63-8*i -: 8] = (b * 8 + i < len) ? seed + 8'(b * 8 + i) : 8'hA5;
      in_last = (b == nb - 1);
      in_bytes = in_last ? 4'(len - 8 * b) : 4'd3;
      in_valid = 1'b1;
      while (!in_ready && cnt < 300) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (cnt >= 300) begin
        n_vec++;
        n_err++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, want 1", cnt);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic drain();
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 500) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d blocks outstanding, want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask
  // Monitor: compare each accepted block against the scoreboard head
  always @(negedge clk) begin
    blk_t e;
    if (!rst && blk_valid && blk_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_block: got unexpected block first=%b last=%b, want none", blk_first, blk_last);
      end else begin
        e = sb.pop_front();
        chk("blk_data", blk_data, e.d);
        chk("blk_first", 1600'(blk_first), 1600'(e.f));
        chk("blk_last", 1600'(blk_last), 1600'(e.l));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end
  initial begin
    logic [1599:0] exp_a;
    int cnt;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    in_bytes = '0;
    mode = 3'b011;
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 1600'(blk_valid), 1600'(0));
    chk("rst_busy", 1600'(busy), 1600'(0));
    chk("rst_data", blk_data, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 1600'(in_ready), 1600'(1));
    push(mk(3, 0, 8'h61, 3, 8'h06, 135), 1'b1, 1'b1);
    send(3'b011, 3, 8'h61, 1'b0);
    chk("busy_mid", 1600'(busy), 1600'(1));
    drain();
    chk("busy_end", 1600'(busy), 1600'(0));
    push(mk(0, 0, 8'h00, 0, 8'h1F, 167), 1'b1, 1'b1);
    send(3'b100, 0, 8'h00, 1'b0);
    drain();
    push(mk(72, 0, 8'h10, -1, 8'h00, -1), 1'b1, 1'b0);
    push(mk(0, 0, 8'h00, 0, 8'h06, 71), 1'b0, 1'b1);
    send(3'b000, 72, 8'h10, 1'b0);
    drain();
    push(mk(143, 0, 8'h20, 143, 8'h06, 143), 1'b1, 1'b1);
    send(3'b010, 143, 8'h20, 1'b0);
    drain();
    push(mk(135, 0, 8'h30, 135, 8'h06, 135), 1'b1, 1'b1);
    send(3'b110, 135, 8'h30, 1'b0);
    drain();
    push(mk(104, 0, 8'h40, -1, 8'h00, -1), 1'b1, 1'b0);
    push(mk(30, 104, 8'h40, 30, 8'h06, 103), 1'b0, 1'b1);
    send(3'b001, 134, 8'h40, 1'b0);
    drain();
    exp_a = mk(20, 0, 8'h50, 20, 8'h06, 135);
    push(exp_a, 1'b1, 1'b1);
    push(mk(136, 0, 8'h60, -1, 8'h00, -1), 1'b1, 1'b0);
    push(mk(0, 0, 8'h00, 0, 8'h1F, 135), 1'b0, 1'b1);
    blk_ready = 1'b0;
    fork
      begin
        send(3'b011, 20, 8'h50, 1'b1);
        send(3'b101, 136, 8'h60, 1'b0);
      end
      begin
        cnt = 0;
        while (!blk_valid && cnt < 100) begin
          @(negedge clk);
          cnt++;
        end
        repeat (5) begin
          chk("stall_data", blk_data, exp_a);
          chk("stall_in_ready", 1600'(in_ready), 1600'(0));
          chk("stall_valid", 1600'(blk_valid), 1600'(1));
          @(negedge clk);
        end
        @(posedge clk); #1;
        blk_ready = 1'b1;
      end
    join
    drain();
    blk_ready = 1'b0;
    push(mk(72, 0, 8'h70, -1, 8'h00, -1), 1'b1, 1'b0);
    push(mk(0, 0, 8'h00, 0, 8'h06, 71), 1'b0, 1'b1);
    send(3'b000, 72, 8'h70, 1'b0);
    chk("pre_rst_valid", 1600'(blk_valid), 1600'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 1600'(blk_valid), 1600'(0));
    chk("mid_rst_first", 1600'(blk_first), 1600'(0));
    chk("mid_rst_last", 1600'(blk_last), 1600'(0));
    chk("mid_rst_busy", 1600'(busy), 1600'(0));
    chk("mid_rst_data", blk_data, '0);
    chk("mid_rst_in_ready", 1600'(in_ready), 1600'(1));
    sb.delete();
    blk_ready = 1'b1;
    push(mk(3, 0, 8'h61, 3, 8'h06, 135), 1'b1, 1'b1);
    send(3'b011, 3, 8'h61, 1'b0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
